ser_word_rx: RTL and testbench

SER_WORD_RX -- requirements
Module: ser_word_rx

---
 rtl/ser_word_rx.sv | 122 ++++++++++++
 tb/tb_ser_word_rx.sv | 136 +++++++++++++
 2 files changed

// File: rtl/ser_word_rx.sv
// Serial word receiver: synchronizes an external sclk/sdin/sdone link, samples on falling sclk,
// delivers WIDTH-bit words MSB first and flags short/long frames with a saturating error count.
module ser_word_rx #(
  parameter int WIDTH = 30,
  parameter int ERRW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             sdin,
  input  logic             sdone,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  output logic             frame_err,
  output logic [ERRW-1:0]  err_cnt,
  output logic             busy
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0]   LAST    = BW'(WIDTH - 1);
  localparam logic [ERRW-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {HUNT, IDLE, SHIFT, TAIL} state_t;
  state_t state;

  logic [1:0]       sclk_q, sdin_q, sdone_q;
  logic             sclk_s, sdin_s, sdone_s;
  logic             sclk_d, sample;
  logic [BW-1:0]    bitcnt;
  logic [WIDTH-1:0] shreg;
  logic             word_done, long_seen;

  assign sclk_s  = sclk_q[1];
  assign sdin_s  = sdin_q[1];
  assign sdone_s = sdone_q[1];

  // sample is registered so a full word lands on dvalid 5 clk after the last falling sclk
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q  <= '0;
      sdin_q  <= '0;
      sdone_q <= '0;
      sclk_d  <= 1'b0;
      sample  <= 1'b0;
    end else begin
      sclk_q  <= {sclk_q[0], sclk};
      sdin_q  <= {sdin_q[0], sdin};
      sdone_q <= {sdone_q[0], sdone};
      sclk_d  <= sclk_s;
      sample  <= sclk_d & ~sclk_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HUNT;
      bitcnt    <= '0;
      shreg     <= '0;
      word_done <= 1'b0;
      long_seen <= 1'b0;
      dout      <= '0;
      dvalid    <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      word_done <= 1'b0;
      frame_err <= 1'b0;
      dvalid    <= word_done;
      if (word_done) dout <= shreg;
      case (state)
        HUNT: begin
          busy <= 1'b0;
          if (sdone_s) state <= IDLE;
        end
        IDLE: begin
          busy <= 1'b0;
          if (!sdone_s) begin
            state     <= SHIFT;
            busy      <= 1'b1;
            bitcnt    <= '0;
            shreg     <= '0;
            long_seen <= 1'b0;
          end
        end
        SHIFT: begin
          // a sample arriving with sdone is consumed first; only an incomplete word errors
          if (sample) begin
            shreg  <= {shreg[WIDTH-2:0], sdin_s};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == LAST) begin
              word_done <= 1'b1;
              state     <= TAIL;
            end else if (sdone_s) begin
              frame_err <= 1'b1;
              state     <= IDLE;
              busy      <= 1'b0;
            end
          end else if (sdone_s) begin
            frame_err <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        TAIL: begin
          if (sample && !long_seen) begin
            frame_err <= 1'b1;
            long_seen <= 1'b1;
          end
          if (sdone_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                             err_cnt <= '0;
    else if (frame_err && err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
  end
endmodule

// File: tb/tb_ser_word_rx.sv
// Randomized bench for ser_word_rx: a bit-level transmitter drives two receivers (ERRW=8 and ERRW=2)
// and a frame-level model predicts words, frame errors and saturating error counts.
module tb_ser_word_rx;
  localparam int W = 30;

  logic         clk = 1'b0, reset = 1'b1, sclk = 1'b0, sdin = 1'b0, sdone = 1'b1;
  logic [W-1:0] dout, dout2;
  logic         dvalid, frame_err, busy, dvalid2, frame_err2, busy2;
  logic [7:0]   err_cnt;
  logic [1:0]   err_cnt2;

  ser_word_rx #(.WIDTH(W), .ERRW(8)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .sdin(sdin), .sdone(sdone),
    .dout(dout), .dvalid(dvalid), .frame_err(frame_err), .err_cnt(err_cnt), .busy(busy));

  ser_word_rx #(.WIDTH(W), .ERRW(2)) dut2 (
    .clk(clk), .reset(reset), .sclk(sclk), .sdin(sdin), .sdone(sdone),
    .dout(dout2), .dvalid(dvalid2), .frame_err(frame_err2), .err_cnt(err_cnt2), .busy(busy2));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, fall_cyc = 0;
  int dv_cnt = 0, fe_cnt = 0, both_cnt = 0;
  logic [W-1:0] last_dv;
  logic [W-1:0] exp_dout;
  int e8 = 0, e2 = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    if (dvalid) begin
      dv_cnt++;
      last_dv = dout;
      chk("latency", 64'(cyc - fall_cyc), 64'd5);
    end
    if (frame_err) fe_cnt++;
    if (dvalid && frame_err) both_cnt++;
  end

  // drives one frame, MSB first; rst_at >= 0 pulses reset after that bit's falling edge
  task automatic send(input logic [63:0] bits, input int n, input int half, input int rst_at);
    sdone = 1'b0;
    repeat (half) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b1;
      sdin = bits[n-1-i];
      repeat (half) @(negedge clk);
      sclk = 1'b0;
      if (i == W - 1) fall_cyc = cyc;
      if (i == 10 && rst_at < 0) chk("busy_mid", 64'(busy), 64'd1);
      if (i == 20 && rst_at >= 0) chk("busy_hunt", 64'(busy), 64'd0);
      if (i == rst_at) begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
      end
      repeat (half) @(negedge clk);
    end
    sdone = 1'b1;
    repeat (2 * half) @(negedge clk);
  endtask

  task automatic run_frame(input logic [63:0] bits, input int n, input int half, input int rst_at);
    int dv0, fe0, xdv, xfe;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send(bits, n, half, rst_at);
    if (rst_at >= 0) begin
      exp_dout = '0; e8 = 0; e2 = 0; xdv = 0; xfe = 0;
    end else if (n >= W) begin
      exp_dout = W'(bits >> (n - W));
      xdv = 1;
      xfe = (n > W) ? 1 : 0;
    end else begin
      xdv = 0;
      xfe = 1;
    end
    if (xfe != 0) begin
      e8 = (e8 < 255) ? e8 + 1 : 255;
      e2 = (e2 < 3) ? e2 + 1 : 3;
    end
    chk("dv_cnt", 64'(dv_cnt - dv0), 64'(xdv));
    chk("fe_cnt", 64'(fe_cnt - fe0), 64'(xfe));
    chk("dout", 64'(dout), 64'(exp_dout));
    if (xdv != 0) chk("dv_word", 64'(last_dv), 64'(exp_dout));
    chk("err_cnt", 64'(err_cnt), 64'(e8));
    chk("err_cnt_sat", 64'(err_cnt2), 64'(e2));
  endtask

  initial begin
    logic [63:0] r;
    int n, sel;
    exp_dout = '0;
    repeat (3) @(negedge clk);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_dvalid", 64'(dvalid), 64'd0);
    chk("rst_ferr", 64'(frame_err), 64'd0);
    chk("rst_errcnt", 64'(err_cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    run_frame(64'h2AAAAAAA, W, 25, -1);
    run_frame(64'h3FFFFFFF, W, 6, -1);
    run_frame(64'h00000001, W, 6, -1);
    run_frame(64'h15555555, W, 6, -1);
    run_frame(64'h0000_0A5C, 12, 5, -1);
    run_frame({$urandom, $urandom}, 33, 5, -1);
    run_frame({$urandom, $urandom}, W, 5, 15);
    run_frame(64'h1234_5678, W, 4, -1);
    for (int k = 0; k < 5; k++) run_frame({$urandom, $urandom}, 12, 4, -1);
    chk("sat_hold", 64'(err_cnt2), 64'd3);

    for (int k = 0; k < 10; k++) begin
      r   = {$urandom, $urandom};
      sel = $urandom_range(0, 3);
      if (sel < 2)       n = W;
      else if (sel == 2) n = $urandom_range(1, W - 1);
      else               n = W + $urandom_range(1, 3);
      run_frame(r, n, $urandom_range(4, 7), -1);
    end

    chk("dv_fe_excl", 64'(both_cnt), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
